// File: rtl/gpr_dbg_master.sv
// Debug-side initiator for the GPR file JTAG port: runs single writes and
// single/burst reads while the core is halted, retrying writes lost to writeback.
module gpr_dbg_master #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_RETRY = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              halted_i,
  input  logic              core_rd_we_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [ADDR_W:0]   cmd_count_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_last_o,
  output logic              jtag_reg_req_o,
  output logic [ADDR_W-1:0] jtag_reg_addr_o,
  output logic              jtag_reg_we_o,
  output logic [DATA_W-1:0] jtag_reg_wdata_o,
  input  logic [DATA_W-1:0] jtag_reg_rdata_i
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned SUM_W = ADDR_W + 2;
  localparam int unsigned NREG  = 1 << ADDR_W;
  localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e             state_q;
  logic               ready_q;
  logic               write_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [CNT_W-1:0]   count_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [RTY_W-1:0]   retry_q;
  logic               rsp_valid_q;
  logic [DATA_W-1:0]  rsp_rdata_q;
  logic               rsp_err_q;
  logic               rsp_last_q;
  logic               req_q;
  logic               we_q;
  logic [ADDR_W-1:0]  jaddr_q;
  logic [DATA_W-1:0]  jwdata_q;

  logic [SUM_W-1:0]   span_c;
  logic               cmd_bad_c;
  logic               retry_again_c;

  // Commands rejected at accept never touch the register port.
  assign span_c    = SUM_W'(cmd_addr_i) + SUM_W'(cmd_count_i);
  assign cmd_bad_c = !halted_i
                  || (cmd_count_i == '0)
                  || (cmd_count_i > CNT_W'(NREG))
                  || (span_c > SUM_W'(NREG))
                  || (cmd_write_i && (cmd_count_i != CNT_W'(1)));

  // A lost write is retried in place until the retry budget runs out.
  assign retry_again_c = halted_i && write_q && core_rd_we_i
                      && (retry_q != RTY_W'(MAX_RETRY - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      count_q     <= '0;
      wdata_q     <= '0;
      retry_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_last_q  <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      jaddr_q     <= '0;
      jwdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (ready_q && cmd_valid_i) begin
            ready_q <= 1'b0;
            write_q <= cmd_write_i;
            addr_q  <= cmd_addr_i;
            count_q <= cmd_count_i;
            wdata_q <= cmd_wdata_i;
            retry_q <= '0;
            if (cmd_bad_c) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= '0;
              rsp_err_q   <= 1'b1;
              rsp_last_q  <= 1'b1;
            end else begin
              state_q  <= ACCESS;
              req_q    <= 1'b1;
              we_q     <= cmd_write_i;
              jaddr_q  <= cmd_addr_i;
              jwdata_q <= cmd_wdata_i;
            end
          end
        end

        ACCESS: begin
          if (retry_again_c) begin
            retry_q <= retry_q + RTY_W'(1);
          end else begin
            // Reaching here with a colliding write means the retries are spent.
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= (halted_i && !write_q) ? jtag_reg_rdata_i : '0;
            rsp_err_q   <= !halted_i || (write_q && core_rd_we_i);
            rsp_last_q  <= !halted_i || write_q || (count_q == CNT_W'(1));
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            jaddr_q     <= '0;
            jwdata_q    <= '0;
          end
        end

        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
            if (rsp_last_q || rsp_err_q) begin
              state_q <= IDLE;
              ready_q <= 1'b1;
            end else begin
              state_q  <= ACCESS;
              addr_q   <= addr_q + ADDR_W'(1);
              count_q  <= count_q - CNT_W'(1);
              retry_q  <= '0;
              req_q    <= 1'b1;
              we_q     <= write_q;
              jaddr_q  <= addr_q + ADDR_W'(1);
              jwdata_q <= wdata_q;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o      = ready_q;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_rdata_o      = rsp_rdata_q;
  assign rsp_err_o        = rsp_err_q;
  assign rsp_last_o       = rsp_last_q;
  // A halt loss in the access cycle itself must keep the request off the port.
  assign jtag_reg_req_o   = req_q & halted_i;
  assign jtag_reg_we_o    = we_q & halted_i;
  assign jtag_reg_addr_o  = jaddr_q;
  assign jtag_reg_wdata_o = jwdata_q;

endmodule

// File: tb/tb_gpr_dbg_master.sv
// Bench for gpr_dbg_master: register-file stand-in plus an array model of the
// expected register contents, directed cases followed by random commands.
module tb_gpr_dbg_master;

  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MAX_RETRY = 4;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              halted_i = 1'b1;
  logic              core_rd_we_i = 1'b0;
  logic              cmd_valid_i = 1'b0;
  logic              cmd_ready_o;
  logic              cmd_write_i = 1'b0;
  logic [ADDR_W-1:0] cmd_addr_i = '0;
  logic [ADDR_W:0]   cmd_count_i = '0;
  logic [DATA_W-1:0] cmd_wdata_i = '0;
  logic              rsp_valid_o;
  logic              rsp_ready_i = 1'b0;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;
  logic              rsp_last_o;
  logic              jtag_reg_req_o;
  logic [ADDR_W-1:0] jtag_reg_addr_o;
  logic              jtag_reg_we_o;
  logic [DATA_W-1:0] jtag_reg_wdata_o;
  logic [DATA_W-1:0] jtag_reg_rdata_i;

  logic [DATA_W-1:0] rf    [32];
  logic [DATA_W-1:0] model [32];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpr_dbg_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_RETRY(MAX_RETRY)) dut (
    .clk_i(clk), .rst_i(rst_i), .halted_i(halted_i), .core_rd_we_i(core_rd_we_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_count_i(cmd_count_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_last_o(rsp_last_o), .jtag_reg_req_o(jtag_reg_req_o),
    .jtag_reg_addr_o(jtag_reg_addr_o), .jtag_reg_we_o(jtag_reg_we_o),
    .jtag_reg_wdata_o(jtag_reg_wdata_o), .jtag_reg_rdata_i(jtag_reg_rdata_i)
  );

  function automatic logic [DATA_W-1:0] seed_val(input int i);
    if (i == 0) return '0;
    if (i == 5) return 32'h1234_5678;
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_1111);
  endfunction

  // Register file stand-in: core writeback wins any collision, x0 is hardwired.
  assign jtag_reg_rdata_i = (jtag_reg_addr_o == '0) ? '0 : rf[jtag_reg_addr_o];
  always @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) rf[i] <= seed_val(i);
    end else if (jtag_reg_req_o && jtag_reg_we_o && !core_rd_we_i && jtag_reg_addr_o != '0) begin
      rf[jtag_reg_addr_o] <= jtag_reg_wdata_o;
    end
  end

  task automatic reload_model();
    for (int i = 0; i < 32; i++) model[i] = seed_val(i);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input logic [DATA_W-1:0] rd, input bit err, input bit last);
    check("rsp_valid", 64'(rsp_valid_o), 64'(1));
    check("rsp_rdata", 64'(rsp_rdata_o), 64'(rd));
    check("rsp_err",   64'(rsp_err_o),   64'(err));
    check("rsp_last",  64'(rsp_last_o),  64'(last));
  endtask

  // Issue one command, then walk every element: attempt count, port values,
  // response contents, and response stability while rsp_ready_i is held low.
  task automatic exec(input bit w, input int a, input int c, input logic [DATA_W-1:0] d,
                      input int coll_n, input int stall, input int hd);
    bit early;
    int att;
    int exp_att;
    bit exp_err;
    bit exp_last;
    logic [DATA_W-1:0] exp_rd;
    early = !halted_i || c == 0 || c > 32 || a + c > 32 || (w && c != 1);
    check("cmd_ready_idle", 64'(cmd_ready_o), 64'(1));
    cmd_write_i = w;
    cmd_addr_i  = ADDR_W'(a);
    cmd_count_i = (ADDR_W+1)'(c);
    cmd_wdata_i = d;
    cmd_valid_i = 1'b1;
    cyc();
    cmd_valid_i = 1'b0;
    cmd_write_i = 1'($urandom);
    cmd_addr_i  = ADDR_W'($urandom);
    cmd_wdata_i = $urandom;
    check("cmd_ready_busy", 64'(cmd_ready_o), 64'(0));
    for (int i = 0; i < (early ? 1 : c); i++) begin
      if (early) begin
        check("early_no_req", 64'(jtag_reg_req_o), 64'(0));
        exp_rd = '0; exp_err = 1'b1; exp_last = 1'b1;
      end else if (i == hd) begin
        halted_i = 1'b0;
        #1;
        check("abort_req", 64'(jtag_reg_req_o), 64'(0));
        check("abort_we",  64'(jtag_reg_we_o),  64'(0));
        cyc();
        halted_i = 1'b1;
        exp_rd = '0; exp_err = 1'b1; exp_last = 1'b1;
      end else begin
        att = 0;
        exp_att = !w ? 1 : (coll_n >= int'(MAX_RETRY) ? int'(MAX_RETRY) : coll_n + 1);
        while (!rsp_valid_o && att < 16) begin
          check("req",  64'(jtag_reg_req_o),  64'(1));
          check("addr", 64'(jtag_reg_addr_o), 64'(a + i));
          check("we",   64'(jtag_reg_we_o),   64'(w));
          if (w) check("wdata", 64'(jtag_reg_wdata_o), 64'(d));
          core_rd_we_i = w ? (att < coll_n) : 1'($urandom);
          rsp_ready_i  = 1'($urandom);
          att++;
          cyc();
        end
        core_rd_we_i = 1'b0;
        check("attempts", 64'(att), 64'(exp_att));
        exp_err  = w && coll_n >= int'(MAX_RETRY);
        exp_last = exp_err || i == c - 1;
        exp_rd   = w ? '0 : model[a + i];
        if (w && !exp_err && a != 0) model[a] = d;
      end
      check_rsp(exp_rd, exp_err, exp_last);
      check("rsp_req_off", 64'(jtag_reg_req_o), 64'(0));
      for (int s = 0; s < stall; s++) begin
        rsp_ready_i = 1'b0;
        cyc();
        check_rsp(exp_rd, exp_err, exp_last);
      end
      rsp_ready_i = 1'b1;
      cyc();
      rsp_ready_i = 1'b0;
      if (exp_err) break;
    end
    check("back_idle_ready", 64'(cmd_ready_o), 64'(1));
    check("back_idle_valid", 64'(rsp_valid_o), 64'(0));
    check("back_idle_req",   64'(jtag_reg_req_o), 64'(0));
  endtask

  task automatic check_reset_outputs(input bit exp_ready);
    check("rst_ready", 64'(cmd_ready_o),      64'(exp_ready));
    check("rst_valid", 64'(rsp_valid_o),      64'(0));
    check("rst_rdata", 64'(rsp_rdata_o),      64'(0));
    check("rst_err",   64'(rsp_err_o),        64'(0));
    check("rst_last",  64'(rsp_last_o),       64'(0));
    check("rst_req",   64'(jtag_reg_req_o),   64'(0));
    check("rst_addr",  64'(jtag_reg_addr_o),  64'(0));
    check("rst_we",    64'(jtag_reg_we_o),    64'(0));
    check("rst_wdata", 64'(jtag_reg_wdata_o), 64'(0));
  endtask

  initial begin
    int w, a, c;
    reload_model();
    @(negedge clk);
    cyc();
    check_reset_outputs(1'b0);
    rst_i = 1'b0;
    cyc();
    check("ready_after_reset", 64'(cmd_ready_o), 64'(1));

    // Single read, single write then readback.
    exec(1'b0, 5, 1, '0, 0, 0, -1);
    exec(1'b1, 3, 1, 32'hDEAD_BEEF, 0, 1, -1);
    exec(1'b0, 3, 1, '0, 0, 0, -1);

    // Collisions: recoverable and exhausting retries, then readback of x7.
    exec(1'b1, 7, 1, 32'hA1B2_C3D4, 2, 0, -1);
    exec(1'b1, 7, 1, 32'h5555_AAAA, 9, 0, -1);
    exec(1'b0, 7, 1, '0, 0, 0, -1);

    // Burst at the top of the file and range errors.
    exec(1'b0, 30, 2, '0, 0, 3, -1);
    exec(1'b0, 31, 2, '0, 0, 0, -1);
    exec(1'b1, 4, 2, 32'h1111_2222, 0, 0, -1);
    exec(1'b0, 4, 0, '0, 0, 1, -1);
    exec(1'b0, 0, 33, '0, 0, 0, -1);
    exec(1'b0, 0, 32, '0, 0, 0, -1);

    // Halt rules.
    halted_i = 1'b0;
    exec(1'b0, 1, 1, '0, 0, 1, -1);
    halted_i = 1'b1;
    exec(1'b0, 10, 4, '0, 0, 0, 1);

    // x0: writes have no effect, reads return 0.
    exec(1'b1, 0, 1, 32'hFFFF_FFFF, 0, 0, -1);
    exec(1'b0, 0, 2, '0, 0, 0, -1);

    // Reset while a burst response is pending.
    cmd_write_i = 1'b0; cmd_addr_i = 5'd8; cmd_count_i = 6'd4; cmd_valid_i = 1'b1;
    cyc();
    cmd_valid_i = 1'b0;
    cyc();
    check("pre_reset_valid", 64'(rsp_valid_o), 64'(1));
    rst_i = 1'b1;
    cyc();
    check_reset_outputs(1'b0);
    rst_i = 1'b0;
    reload_model();
    cyc();
    check("ready_after_midreset", 64'(cmd_ready_o), 64'(1));
    check("req_after_midreset", 64'(jtag_reg_req_o), 64'(0));
    exec(1'b0, 8, 3, '0, 0, 1, -1);

    // Random mix of commands, including occasional malformed ones.
    for (int n = 0; n < 40; n++) begin
      w = ($urandom_range(0, 3) == 0) ? 1 : 0;
      a = $urandom_range(0, 31);
      c = (w == 1) ? 1 : $urandom_range(1, 32 - a);
      if ($urandom_range(0, 7) == 0) c = $urandom_range(0, 40);
      exec(1'(w), a, c, $urandom, (w == 1) ? $urandom_range(0, 5) : 0,
           $urandom_range(0, 2), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
